even_parity_encoder_tx: RTL and testbench
=========================================

// Module: even_parity_encoder_tx
// PURPOSE
//  Transmit-side counterpart of the even-parity checker.
//  - Accepts a DATA_W-bit word over a valid/ready handshake and computes its even-parity bit.
//  - Serializes data bits LSB first, then the parity bit, one bit per clock.
//  - Also presents the full parallel codeword {parity, data}.
// PARAMETERS
//  DATA_W   4   data bits per word (>=2); codeword is DATA_W+1 bits
//  CNT_W    8   width of the sent-frame counter
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         in_data is valid
//  in_data    in   DATA_W    word to encode
//  in_ready   out  1         block can accept a word this cycle
//  tx_bit     out  1         serial output bit
//  tx_valid   out  1         tx_bit is valid this cycle
//  tx_last    out  1         tx_bit is the parity bit (final bit of frame)
//  code_word  out  DATA_W+1  {parity, data} of the current/last accepted word
//  frame_cnt  out  CNT_W     number of completed frames, wraps
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE.
//  - in_ready=1; all other outputs = 0.
//  - Shift register and bit counter cleared.
//  Parity: par = ^in_data (even parity, so {par,data} has an even number of 1s).
//  - Computed combinationally at accept, registered with the data.
//  FSM with two states: IDLE, SHIFT.
//  - IDLE:
//    - in_ready=1, tx_valid=0.
//    - in_valid&&in_ready: load shreg={par,in_data}, code_word={par,in_data}, bit_idx=0.
//    - Then go to SHIFT.
//  - SHIFT:
//    - tx_valid=1, tx_bit=shreg[0]; shift right each cycle; bit_idx++.
//    - tx_last=1 when bit_idx==DATA_W.
//  - Frame timing:
//    - The first bit appears the cycle after accept (latency 1).
//    - The frame occupies exactly DATA_W+1 consecutive cycles.
//  - Back-to-back: in_ready=1 also during the tx_last cycle.
//    - If a word is accepted then, reload and stay in SHIFT.
//    - The next frame's bit 0 follows the parity bit with no gap.
//    - Otherwise return to IDLE.
//  - in_ready=0 for all other SHIFT cycles; in_valid is ignored then and the word is not consumed.
//  frame_cnt increments on the clock edge ending each tx_last cycle.
//  - Wraps 2^CNT_W-1 -> 0.
//  code_word holds until the next accept; it is not cleared at frame end.
//  Reset asserted mid-frame:
//  - Frame aborted immediately (async): tx_valid=0, frame_cnt=0, state=IDLE.
//  - The aborted frame is not counted.
//  in_data is sampled only at accept; later changes have no effect on the frame in flight.
// CONFIGURATION
//  ODD_PARITY_EN:
//  - Defined: par = ~^in_data, so the codeword has an odd number of 1s.
//  - Undefined: even parity as above.
//  - Timing, handshake and all other behaviour identical in both builds.
// TESTING
//  1. Reset, then idle: in_ready=1, tx_valid=0, code_word=0, frame_cnt=0.
//  2. Accept 4'b0110:
//     - tx_bit sequence 0,1,1,0,0 on cycles 1..5; tx_last only on cycle 5.
//     - code_word=5'b00110; frame_cnt=1.
//  3. Accept 4'b0111: parity 1, tx_bit seq 1,1,1,0,1, code_word=5'b10111.
//     - With ODD_PARITY_EN: parity 0, code_word=5'b00111.
//  4. Back-to-back: 4'hA then 4'h3 offered on the tx_last cycle.
//     - 10 contiguous tx_valid cycles: 0,1,0,1,0 then 1,1,0,0,0; frame_cnt=2.
//  5. in_valid held with 4'hF during mid-frame cycles: not accepted until the tx_last cycle.
//     - Parity 0, exactly one frame sent.
//  6. Assert rst at bit 2 of a frame: outputs clear within the same cycle.
//     - After release, sweep all 16 inputs: every code_word has even weight; frame_cnt=16.

Source files
------------

// File: rtl/even_parity_encoder_tx.sv
// Parity encoder / serializer: accepts a word over valid/ready, shifts out data LSB first then parity.
// Build option: define ODD_PARITY_EN to generate odd parity instead of even parity.
module even_parity_encoder_tx #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last,
    output logic [DATA_W:0]   code_word,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W:0]     shreg_r;
    logic [IDX_W-1:0]    bit_idx_r;
    logic [DATA_W:0]     code_word_r;
    logic [CNT_W-1:0]    frame_cnt_r;
    logic                last_s;
    logic                ready_s;
    logic                accept_s;
    logic [DATA_W:0]     code_s;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
`ifdef ODD_PARITY_EN
        return ~^d;
`else
        return ^d;
`endif
    endfunction

    // Handshake and codeword formation
    always_comb begin
        last_s   = 1'b0;
        ready_s  = 1'b0;
        accept_s = 1'b0;
        code_s   = {parity_of(in_data), in_data};
        if (state_r == ST_SHIFT) begin
            last_s  = (bit_idx_r == LAST_IDX);
            ready_s = last_s;
        end else begin
            last_s  = 1'b0;
            ready_s = 1'b1;
        end
        accept_s = in_valid && ready_s;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a word accepted on the parity cycle chains straight into the next frame
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s && !accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Shift register, bit index and held codeword
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r     <= '0;
            bit_idx_r   <= '0;
            code_word_r <= '0;
        end else if (accept_s) begin
            shreg_r     <= code_s;
            bit_idx_r   <= '0;
            code_word_r <= code_s;
        end else if (state_r == ST_SHIFT) begin
            shreg_r     <= {1'b0, shreg_r[DATA_W:1]};
            bit_idx_r   <= bit_idx_r + IDX_W'(1);
            code_word_r <= code_word_r;
        end else begin
            shreg_r     <= shreg_r;
            bit_idx_r   <= bit_idx_r;
            code_word_r <= code_word_r;
        end
    end

    // Completed-frame counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= '0;
        end else if (last_s) begin
            frame_cnt_r <= frame_cnt_r + CNT_W'(1);
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Output decode from registered state only, so async reset clears them at once
    always_comb begin
        tx_valid  = 1'b0;
        tx_bit    = 1'b0;
        tx_last   = 1'b0;
        in_ready  = ready_s;
        code_word = code_word_r;
        frame_cnt = frame_cnt_r;
        case (state_r)
            ST_SHIFT: begin
                tx_valid = 1'b1;
                tx_bit   = shreg_r[0];
                tx_last  = last_s;
            end
            ST_IDLE: begin
                tx_valid = 1'b0;
                tx_bit   = 1'b0;
                tx_last  = 1'b0;
            end
            default: begin
                tx_valid = 1'b0;
                tx_bit   = 1'b0;
                tx_last  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_even_parity_encoder_tx.sv
// Directed self-checking bench for even_parity_encoder_tx (DATA_W=4, CNT_W=8).
module tb_even_parity_encoder_tx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_last;
    logic [4:0] code_word;
    logic [7:0] frame_cnt;

    int n_checks;
    int n_errors;
    int exp_frames;

`ifdef ODD_PARITY_EN
    localparam logic [4:0] CODE_6 = 5'b10110;
    localparam logic [4:0] CODE_7 = 5'b00111;
    localparam logic [4:0] CODE_A = 5'b11010;
    localparam logic [4:0] CODE_3 = 5'b10011;
    localparam logic [4:0] CODE_5 = 5'b10101;
    localparam logic [4:0] CODE_F = 5'b11111;
    localparam logic       WEIGHT_PAR = 1'b1;
`else
    localparam logic [4:0] CODE_6 = 5'b00110;
    localparam logic [4:0] CODE_7 = 5'b10111;
    localparam logic [4:0] CODE_A = 5'b01010;
    localparam logic [4:0] CODE_3 = 5'b00011;
    localparam logic [4:0] CODE_5 = 5'b00101;
    localparam logic [4:0] CODE_F = 5'b01111;
    localparam logic       WEIGHT_PAR = 1'b0;
`endif

    even_parity_encoder_tx #(.DATA_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .code_word (code_word),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref_code(input logic [3:0] d);
`ifdef ODD_PARITY_EN
        return {~^d, d};
`else
        return {^d, d};
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a word at a negedge; returns at the next negedge (frame cycle 1) with in_valid low.
    task automatic start_word(input logic [3:0] d);
        check_val("ready_at_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Check the 5 bits of a frame starting at cycle 1; optionally offer the next word on tx_last.
    task automatic frame_bits(input logic [4:0] code, input logic nxt_v, input logic [3:0] nxt_d);
        for (int i = 0; i < 5; i++) begin
            check_val("tx_valid", 32'(tx_valid), 32'd1);
            check_val("tx_bit", 32'(tx_bit), 32'(code[i]));
            check_val("tx_last", 32'(tx_last), (i == 4) ? 32'd1 : 32'd0);
            check_val("in_ready", 32'(in_ready), (i == 4) ? 32'd1 : 32'd0);
            if (i == 0) check_val("code_word", 32'(code_word), 32'(code));
            if (i == 4) begin
                in_valid = nxt_v;
                in_data  = nxt_d;
            end
            @(negedge clk);
            if (i == 4) in_valid = 1'b0;
        end
        exp_frames++;
        check_val("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check_val("tx_valid_after", 32'(tx_valid), 32'(nxt_v));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_frames = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset / idle state
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_val("rst_tx_last", 32'(tx_last), 32'd0);
        check_val("rst_tx_bit", 32'(tx_bit), 32'd0);
        check_val("rst_code", 32'(code_word), 32'd0);
        check_val("rst_cnt", 32'(frame_cnt), 32'd0);

        // Single frames
        start_word(4'b0110);
        frame_bits(CODE_6, 1'b0, 4'h0);
        check_val("code_hold_6", 32'(code_word), 32'(CODE_6));
        start_word(4'b0111);
        frame_bits(CODE_7, 1'b0, 4'h0);
        check_val("code_hold_7", 32'(code_word), 32'(CODE_7));
        @(negedge clk);

        // Back-to-back A then 3
        start_word(4'hA);
        frame_bits(CODE_A, 1'b1, 4'h3);
        frame_bits(CODE_3, 1'b0, 4'h0);

        // Word held valid mid-frame is only taken on tx_last; in_data change mid-frame ignored
        start_word(4'h5);
        in_valid = 1'b1;
        in_data  = 4'hF;
        frame_bits(CODE_5, 1'b1, 4'hF);
        frame_bits(CODE_F, 1'b0, 4'h0);
        @(negedge clk);
        check_val("no_extra_frame", 32'(tx_valid), 32'd0);
        check_val("cnt_after_hold", 32'(frame_cnt), 32'(exp_frames));

        // Async reset at bit 2 of a frame
        start_word(4'h9);
        @(negedge clk);
        @(negedge clk);
        check_val("pre_rst_valid", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_valid", 32'(tx_valid), 32'd0);
        check_val("abort_last", 32'(tx_last), 32'd0);
        check_val("abort_cnt", 32'(frame_cnt), 32'd0);
        check_val("abort_ready", 32'(in_ready), 32'd1);
        check_val("abort_code", 32'(code_word), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        @(negedge clk);

        // Sweep all inputs
        for (int v = 0; v < 16; v++) begin
            start_word(4'(v));
            check_val("sweep_weight", 32'(^code_word), 32'(WEIGHT_PAR));
            frame_bits(ref_code(4'(v)), 1'b0, 4'h0);
        end
        check_val("sweep_cnt", 32'(frame_cnt), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
